// File: rtl/i2s_tx.sv
// Master-mode I2S / left-justified transmitter with an internal first-word-fall-through sample FIFO.
// SCK and WS are derived from clk by a prescaler. All data and framing updates happen on the SCK falling event.

module i2s_tx #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [7:0]    sck_prescaler,
   input  logic          left_justified,
   input  logic [5:0]    sample_size,
   input  logic [1:0]    channels,
   input  logic          fifo_wr,
   input  logic [31:0]   fifo_wdata,
   input  logic          fifo_flush,
   output logic          fifo_full,
   output logic          fifo_empty,
   output logic [AW:0]   fifo_level,
   output logic          underflow,
   output logic          sck,
   output logic          ws,
   output logic          sdo
);

   localparam int              DEPTH      = 1 << AW;
   localparam logic [AW:0]     FULL_LEVEL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]     LVL_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

   // ---------------- sample FIFO ----------------
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [31:0]   fifo_rdata;
   logic          pop_req;
   logic          do_push;
   logic          do_pop;

   assign fifo_full  = (level_q == FULL_LEVEL);
   assign fifo_empty = (level_q == '0);
   assign fifo_level = level_q;
   assign fifo_rdata = mem_q[rd_ptr_q];

   // A pop frees a slot in the same clk, so a full FIFO still accepts a simultaneous push.
   assign do_pop  = pop_req & ~fifo_empty;
   assign do_push = fifo_wr & (~fifo_full | do_pop);

   always_comb begin
      // NOTE: every target gets a default first, so no path through the block can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (fifo_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   // NOTE: registers use non-blocking assignments so each one samples pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: sample storage is deliberately not reset; clearing the pointers and level discards its contents.
   always_ff @(posedge clk) begin
      if (do_push && !fifo_flush) mem_q[wr_ptr_q] <= fifo_wdata;
   end

   // ---------------- clock generation and serialiser ----------------
   logic [7:0]  presc_q, presc_d;
   logic        sck_q, sck_d;
   logic        ws_q, ws_d;
   logic        sdo_q, sdo_d;
   logic        dly_q, dly_d;
   logic        uf_q, uf_d;
   logic        lj_q, lj_d;
   logic [4:0]  bit_ctr_q, bit_ctr_d;
   logic [31:0] sr_q, sr_d;
   logic        tick;
   logic        fe;
   logic        boundary;
   logic        slot_sel;
   logic [5:0]  eff_size;
   logic [4:0]  pad_shift;

   assign tick     = en & (presc_q == 8'd0);
   assign fe       = tick & sck_q;
   assign boundary = fe & (bit_ctr_q == 5'd31);

   // The slot about to start belongs to the channel ws switches to: 0 = left, 1 = right.
   assign slot_sel  = ws_q ? channels[1] : channels[0];
   assign pop_req   = boundary & slot_sel;
   assign eff_size  = (sample_size == 6'd0 || sample_size > 6'd32) ? 6'd32 : sample_size;
   assign pad_shift = 5'(6'd32 - eff_size);

   always_comb begin
      presc_d   = presc_q;
      sck_d     = sck_q;
      ws_d      = ws_q;
      bit_ctr_d = bit_ctr_q;
      sr_d      = sr_q;
      dly_d     = dly_q;
      sdo_d     = sdo_q;
      lj_d      = lj_q;
      uf_d      = 1'b0;

      if (tick) begin
         presc_d = sck_prescaler;
         sck_d   = ~sck_q;
      end else if (en) begin
         presc_d = presc_q - 8'd1;
      end

      if (fe) begin
         bit_ctr_d = bit_ctr_q + 5'd1;
         if (boundary) begin
            ws_d = ~ws_q;
            lj_d = left_justified;
            uf_d = slot_sel & fifo_empty;
            if (slot_sel && !fifo_empty) sr_d = fifo_rdata << pad_shift;
            else                         sr_d = '0;
         end else begin
            sr_d = {sr_q[30:0], 1'b0};
         end

         // In I2S mode the extra delay stage lets a slot's last bit spill into the next slot.
         if (lj_d) begin
            sdo_d = sr_d[31];
         end else begin
            sdo_d = dly_q;
            dly_d = sr_d[31];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q   <= '0;
         sck_q     <= 1'b0;
         ws_q      <= 1'b1;
         sdo_q     <= 1'b0;
         dly_q     <= 1'b0;
         uf_q      <= 1'b0;
         lj_q      <= 1'b0;
         bit_ctr_q <= '0;
         sr_q      <= '0;
      end else begin
         presc_q   <= presc_d;
         sck_q     <= sck_d;
         ws_q      <= ws_d;
         sdo_q     <= sdo_d;
         dly_q     <= dly_d;
         uf_q      <= uf_d;
         lj_q      <= lj_d;
         bit_ctr_q <= bit_ctr_d;
         sr_q      <= sr_d;
      end
   end

   assign sck       = sck_q;
   assign ws        = ws_q;
   assign sdo       = sdo_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a monitor assembles 32-bit serial slots from each ws edge and compares them
// against a scoreboard filled when samples are pushed; timing, FIFO and freeze/reset checks run inline.

module tb_i2s_tx;

   localparam int AW = 4;
   localparam int SEL_SCK = 0;
   localparam int SEL_WS  = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [7:0]    sck_prescaler = 8'd1;
   logic          left_justified = 1'b1;
   logic [5:0]    sample_size = 6'd32;
   logic [1:0]    channels = 2'b11;
   logic          fifo_wr = 1'b0;
   logic [31:0]   fifo_wdata = '0;
   logic          fifo_flush = 1'b0;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW:0]   fifo_level;
   logic          underflow;
   logic          sck;
   logic          ws;
   logic          sdo;

   i2s_tx #(.AW(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .sck_prescaler  (sck_prescaler),
      .left_justified (left_justified),
      .sample_size    (sample_size),
      .channels       (channels),
      .fifo_wr        (fifo_wr),
      .fifo_wdata     (fifo_wdata),
      .fifo_flush     (fifo_flush),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .fifo_level     (fifo_level),
      .underflow      (underflow),
      .sck            (sck),
      .ws             (ws),
      .sdo            (sdo)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard and monitor ----------------
   logic [31:0] exp_q[$];
   logic [31:0] last_pad = '0;
   int          cyc = 0;
   int          fe_cnt = 0;
   int          uf_cnt = 0;
   int          nbits = 0;
   logic        sck_prev = 1'b0;
   logic        ws_prev = 1'b1;
   logic        cap_active = 1'b0;
   logic [31:0] cap = '0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst) begin
         sck_prev   = 1'b0;
         ws_prev    = 1'b1;
         fe_cnt     = 0;
         uf_cnt     = 0;
         nbits      = 0;
         cap_active = 1'b0;
         cap        = '0;
      end else begin
         if (underflow) uf_cnt++;
         if (sck_prev && !sck) begin
            fe_cnt++;
            if (ws !== ws_prev) begin
               cap_active = 1'b1;
               nbits      = 0;
               cap        = '0;
            end
            if (cap_active) begin
               cap = {cap[30:0], sdo};
               nbits++;
               if (nbits == 32) begin
                  cap_active = 1'b0;
                  if (exp_q.size() > 0) check("slot", cap, exp_q.pop_front());
               end
            end
         end
         sck_prev = sck;
         ws_prev  = ws;
      end
   end

   function automatic int eff_size(input logic [5:0] s);
      return (s == 6'd0 || s > 6'd32) ? 32 : int'(s);
   endfunction

   // Expected captured slot: LJ shows the padded word; I2S shows the previous slot's last bit then word[31:1].
   task automatic expect_slot(input logic [31:0] pad);
      exp_q.push_back(left_justified ? pad : {last_pad[0], pad[31:1]});
      last_pad = pad;
   endtask

   task automatic expect_sample(input logic [31:0] w);
      expect_slot(w << (32 - eff_size(sample_size)));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      to_drive();
      rst = 1'b1;
      en = 1'b0;
      fifo_wr = 1'b0;
      fifo_flush = 1'b0;
      to_drive();
      rst = 1'b0;
      exp_q.delete();
      last_pad = '0;
   endtask

   task automatic push_word(input logic [31:0] w, input bit expect_it);
      to_drive();
      fifo_wr = 1'b1;
      fifo_wdata = w;
      to_drive();
      fifo_wr = 1'b0;
      if (expect_it) expect_sample(w);
   endtask

   task automatic wait_for(input int sel, input logic val, input string tag);
      int n = 0;
      do begin
         sample();
         n++;
      end while ((((sel == SEL_SCK) ? sck : ws) !== val) && n < 4000);
      if (((sel == SEL_SCK) ? sck : ws) !== val) check({tag, "_timeout"}, ((sel == SEL_SCK) ? sck : ws), val);
   endtask

   task automatic wait_sb_empty(input int budget, input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         sample();
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // Returns at a sample point where the next posedge is the 32nd falling event (prescaler 0).
   task automatic wait_fe31();
      int n = 0;
      do begin
         sample();
         n++;
      end while (!(fe_cnt == 31 && sck === 1'b1) && n < 400);
      if (!(fe_cnt == 31 && sck === 1'b1)) check("fe31_timeout", fe_cnt, 31);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- tests ----------------
   initial begin
      int c1;
      int c_fall;
      int changes;
      logic [2:0] hold;

      // Reset state and basic timing
      do_reset();
      sample();
      check("rst_sck", sck, 1'b0);
      check("rst_ws", ws, 1'b1);
      check("rst_sdo", sdo, 1'b0);
      check("rst_uf", underflow, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_empty", fifo_empty, 1'b1);
      check("rst_full", fifo_full, 1'b0);
      left_justified = 1'b1;
      sample_size = 6'd16;
      channels = 2'b11;
      sck_prescaler = 8'd1;
      to_drive();
      en = 1'b1;
      wait_for(SEL_SCK, 1'b1, "sck_rise1");
      c1 = cyc;
      wait_for(SEL_SCK, 1'b0, "sck_fall1");
      wait_for(SEL_SCK, 1'b1, "sck_rise2");
      check("sck_period", cyc - c1, 4);
      wait_for(SEL_WS, 1'b0, "ws_fall1");
      check("fe_before_ws_fall", fe_cnt, 32);
      check("uf_none_in_first_right", uf_cnt, 1);
      check("uf_at_empty_left", underflow, 1'b1);
      c_fall = cyc;
      wait_for(SEL_WS, 1'b1, "ws_rise1");
      check("ws_low_clks", cyc - c_fall, 128);
      wait_for(SEL_WS, 1'b0, "ws_fall2");
      check("frame_clks", cyc - c_fall, 256);

      // Left-justified stereo, 16-bit samples
      do_reset();
      left_justified = 1'b1;
      sample_size = 6'd16;
      channels = 2'b11;
      sck_prescaler = 8'd1;
      push_word(32'h0000A5C3, 1'b1);
      push_word(32'h00001234, 1'b1);
      expect_slot('0);
      sample();
      check("lj_level2", fifo_level, 2);
      to_drive();
      en = 1'b1;
      wait_for(SEL_WS, 1'b0, "lj_ws_fall");
      check("lj_level1", fifo_level, 1);
      wait_for(SEL_WS, 1'b1, "lj_ws_rise");
      check("lj_level0", fifo_level, 0);
      wait_sb_empty(2000, "lj");

      // I2S framing with 32-bit samples: LSB spills into the next slot
      do_reset();
      left_justified = 1'b0;
      sample_size = 6'd32;
      channels = 2'b11;
      sck_prescaler = 8'd1;
      push_word(32'h80000001, 1'b1);
      push_word(32'hFFFFFFFF, 1'b1);
      expect_slot('0);
      to_drive();
      en = 1'b1;
      wait_sb_empty(2000, "i2s");

      // Mono left with a single 3-bit sample, then underflow
      do_reset();
      left_justified = 1'b1;
      sample_size = 6'd3;
      channels = 2'b10;
      sck_prescaler = 8'd1;
      push_word(32'h00000007, 1'b1);
      expect_slot('0);
      expect_slot('0);
      expect_slot('0);
      to_drive();
      en = 1'b1;
      wait_for(SEL_WS, 1'b0, "mono_left1");
      check("mono_uf_left1", uf_cnt, 0);
      check("mono_level_after_pop", fifo_level, 0);
      wait_for(SEL_WS, 1'b1, "mono_right1");
      check("mono_uf_right", uf_cnt, 0);
      wait_for(SEL_WS, 1'b0, "mono_left2");
      check("mono_uf_pulse", underflow, 1'b1);
      check("mono_uf_cnt", uf_cnt, 1);
      wait_for(SEL_WS, 1'b1, "mono_right2");
      check("mono_uf_one_clk", uf_cnt, 1);
      wait_sb_empty(2000, "mono");

      // FIFO full and flush
      do_reset();
      for (int i = 0; i < 16; i++) push_word(32'h100 + i, 1'b0);
      sample();
      check("full_level16", fifo_level, 16);
      check("full_flag", fifo_full, 1'b1);
      check("full_not_empty", fifo_empty, 1'b0);
      push_word(32'hDEADBEEF, 1'b0);
      sample();
      check("full_17th_ignored", fifo_level, 16);
      to_drive();
      fifo_flush = 1'b1;
      fifo_wr = 1'b1;
      fifo_wdata = 32'h0BADF00D;
      to_drive();
      fifo_flush = 1'b0;
      fifo_wr = 1'b0;
      sample();
      check("flush_level", fifo_level, 0);
      check("flush_empty", fifo_empty, 1'b1);
      check("flush_not_full", fifo_full, 1'b0);

      // Push on the same clk as a boundary: empty FIFO underflows but stores the word
      do_reset();
      left_justified = 1'b1;
      sample_size = 6'd32;
      channels = 2'b11;
      sck_prescaler = 8'd0;
      to_drive();
      en = 1'b1;
      wait_fe31();
      fifo_wr = 1'b1;
      fifo_wdata = 32'hC0FFEE11;
      expect_slot('0);
      expect_sample(32'hC0FFEE11);
      sample();
      fifo_wr = 1'b0;
      check("bnd_empty_uf", underflow, 1'b1);
      check("bnd_empty_level", fifo_level, 1);
      check("bnd_empty_ws", ws, 1'b0);
      wait_sb_empty(600, "bnd_empty");

      // Push on the same clk as a boundary pop while full: level unchanged, order kept
      do_reset();
      for (int i = 0; i < 16; i++) push_word((32'h01010101 * i) ^ 32'hA5000000, 1'b1);
      to_drive();
      en = 1'b1;
      wait_fe31();
      fifo_wr = 1'b1;
      fifo_wdata = 32'h5EED0017;
      expect_sample(32'h5EED0017);
      sample();
      fifo_wr = 1'b0;
      check("bnd_full_level", fifo_level, 16);
      check("bnd_full_flag", fifo_full, 1'b1);
      wait_sb_empty(4000, "bnd_full");

      // Freeze mid-slot, then reset mid-slot (sample_size 40 behaves as 32)
      do_reset();
      left_justified = 1'b1;
      sample_size = 6'd40;
      channels = 2'b11;
      sck_prescaler = 8'd1;
      push_word(32'h12345678, 1'b1);
      push_word(32'h9ABCDEF0, 1'b1);
      to_drive();
      en = 1'b1;
      wait_for(SEL_WS, 1'b0, "frz_ws_fall");
      repeat (41) sample();
      to_drive();
      en = 1'b0;
      sample();
      hold = {sck, ws, sdo};
      changes = 0;
      for (int i = 0; i < 50; i++) begin
         sample();
         if ({sck, ws, sdo} !== hold) changes++;
      end
      check("frz_outputs_held", changes, 0);
      push_word(32'h55AA0F0F, 1'b1);
      sample();
      check("frz_push_level", fifo_level, 2);
      to_drive();
      en = 1'b1;
      wait_for(SEL_WS, 1'b1, "frz_ws_rise");
      check("frz_left_compared", exp_q.size(), 2);
      repeat (10) sample();
      do_reset();
      sample();
      check("mid_rst_sck", sck, 1'b0);
      check("mid_rst_ws", ws, 1'b1);
      check("mid_rst_sdo", sdo, 1'b0);
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_empty", fifo_empty, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
